// File: rtl/flash_pattern_gen.sv
// Adjustable-rate flash pattern source for one bike-light flash mode.
// Rate is one-hot; phase advances every L = BASE_STEP << (NUM_RATES-1-idx) cycles.
module flash_pattern_gen #(
  parameter int unsigned NUM_RATES = 4,
  parameter int unsigned BASE_STEP = 1_250_000,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned PATTERN   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_left,
  input  logic                 shift_right,
  output logic                 light,
  output logic [NUM_RATES-1:0] rate,
  output logic                 step_tick
);

  localparam logic [NUM_RATES-1:0] RATE_RST =
    NUM_RATES'(1) << (NUM_RATES / 2);

  // Terminal count (L-1) for a one-hot rate setting
  function automatic logic [CNT_W-1:0] last_cnt(
    input logic [NUM_RATES-1:0] r
  );
    logic [CNT_W-1:0] len;
    len = '0;
    for (int i = 0; i < NUM_RATES; i++) begin
      if (r[i]) len = CNT_W'(BASE_STEP) << (NUM_RATES - 1 - i);
    end
    return len - CNT_W'(1);
  endfunction

  logic [NUM_RATES-1:0] rate_q, rate_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           phase_q, phase_d;
  logic                 tick_q, tick_d;
  logic                 go_up, go_dn, rate_chg, wrap;

  always_comb begin
    go_up    = shift_left & ~shift_right & ~rate_q[NUM_RATES-1];
    go_dn    = shift_right & ~shift_left & ~rate_q[0];
    rate_chg = go_up | go_dn;
    rate_d   = rate_q;
    unique case (1'b1)
      go_up:   rate_d = rate_q << 1;
      go_dn:   rate_d = rate_q >> 1;
      default: rate_d = rate_q;
    endcase
  end

  always_comb begin
    wrap    = (cnt_q == last_cnt(rate_q));
    cnt_d   = (wrap | rate_chg) ? '0 : cnt_q + CNT_W'(1);
    phase_d = wrap ? phase_q + 3'd1 : phase_q;
    // Tick is registered: flag the cycle whose count will sit at L-1
    tick_d  = (cnt_d == last_cnt(rate_d));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_q  <= RATE_RST;
      cnt_q   <= '0;
      phase_q <= 3'd0;
      tick_q  <= 1'b0;
    end else begin
      rate_q  <= rate_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
    end
  end

  generate
    if (PATTERN == 0) begin : g_square
      always_comb light = ~phase_q[2];
    end else begin : g_strobe
      always_comb light = (phase_q == 3'd0) | (phase_q == 3'd2);
    end
  endgenerate

  assign rate      = rate_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_flash_pattern_gen.sv
// Directed bench for flash_pattern_gen with NUM_RATES=4, BASE_STEP=2, CNT_W=8.
// Two instances share stimulus: PATTERN 0 (square) and PATTERN 1 (strobe).
module tb_flash_pattern_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sl = 1'b0;
  logic       sr = 1'b0;
  logic       l0, l1, t0, t1;
  logic [3:0] r0, r1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  flash_pattern_gen #(
    .NUM_RATES(4), .BASE_STEP(2), .CNT_W(8), .PATTERN(0)
  ) u_p0 (
    .clk(clk), .reset(reset),
    .shift_left(sl), .shift_right(sr),
    .light(l0), .rate(r0), .step_tick(t0)
  );

  flash_pattern_gen #(
    .NUM_RATES(4), .BASE_STEP(2), .CNT_W(8), .PATTERN(1)
  ) u_p1 (
    .clk(clk), .reset(reset),
    .shift_left(sl), .shift_right(sr),
    .light(l1), .rate(r1), .step_tick(t1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sl = 1'b0;
    sr = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (r0 !== 4'b0100) begin
      errors++;
      $display("FAIL reset_rate got %b exp 0100", r0);
    end
    checks++;
    if (t0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick got %b exp 0", t0);
    end
    checks++;
    if (l0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_light0 got %b exp 1", l0);
    end
    checks++;
    if (l1 !== 1'b1 || r1 !== 4'b0100 || t1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_p1 got l=%b r=%b t=%b exp 1 0100 0",
               l1, r1, t1);
    end
  endtask

  task automatic test_idle_square();
    logic et, el;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      et = (k % 4 == 3);
      el = ((k / 4) % 8) < 4;
      checks++;
      if (t0 !== et) begin
        errors++;
        $display("FAIL idle_tick k=%0d got %b exp %b", k, t0, et);
      end
      checks++;
      if (l0 !== el) begin
        errors++;
        $display("FAIL idle_light k=%0d got %b exp %b", k, l0, el);
      end
      cyc();
    end
  endtask

  task automatic test_shift_left_sat();
    logic et;
    do_reset();
    sl = 1'b1;
    cyc();
    sl = 1'b0;
    for (int j = 0; j < 16; j++) begin
      et = (j % 2 == 1);
      checks++;
      if (r0 !== 4'b1000) begin
        errors++;
        $display("FAIL sl_rate j=%0d got %b exp 1000", j, r0);
      end
      checks++;
      if (t0 !== et) begin
        errors++;
        $display("FAIL sl_tick j=%0d got %b exp %b", j, t0, et);
      end
      if (j == 7) begin
        checks++;
        if (l0 !== 1'b1) begin
          errors++;
          $display("FAIL sl_light_on got %b exp 1", l0);
        end
      end
      if (j == 15) begin
        checks++;
        if (l0 !== 1'b0) begin
          errors++;
          $display("FAIL sl_light_off got %b exp 0", l0);
        end
      end
      sl = (j == 2);
      cyc();
    end
    sl = 1'b0;
  endtask

  task automatic test_shift_right_sat();
    logic et, el;
    do_reset();
    sr = 1'b1;
    cyc();
    checks++;
    if (r0 !== 4'b0010) begin
      errors++;
      $display("FAIL sr_rate1 got %b exp 0010", r0);
    end
    cyc();
    checks++;
    if (r0 !== 4'b0001) begin
      errors++;
      $display("FAIL sr_rate2 got %b exp 0001", r0);
    end
    cyc();
    checks++;
    if (r0 !== 4'b0001) begin
      errors++;
      $display("FAIL sr_rate3 got %b exp 0001", r0);
    end
    sr = 1'b0;
    for (int m = 0; m <= 140; m++) begin
      et = (m % 16 == 14);
      el = !(m >= 63 && m <= 126);
      checks++;
      if (t0 !== et) begin
        errors++;
        $display("FAIL sr_tick m=%0d got %b exp %b", m, t0, et);
      end
      checks++;
      if (l0 !== el) begin
        errors++;
        $display("FAIL sr_light m=%0d got %b exp %b", m, l0, el);
      end
      cyc();
    end
  endtask

  task automatic test_both_strobes();
    logic et;
    do_reset();
    for (int j = 0; j < 16; j++) begin
      et = (j % 4 == 3);
      checks++;
      if (r0 !== 4'b0100) begin
        errors++;
        $display("FAIL both_rate j=%0d got %b exp 0100", j, r0);
      end
      checks++;
      if (t0 !== et) begin
        errors++;
        $display("FAIL both_tick j=%0d got %b exp %b", j, t0, et);
      end
      sl = (j == 1);
      sr = (j == 1);
      cyc();
    end
    sl = 1'b0;
    sr = 1'b0;
  endtask

  task automatic test_shift_on_wrap();
    do_reset();
    cyc();
    cyc();
    cyc();
    checks++;
    if (t0 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_tick got %b exp 1", t0);
    end
    sl = 1'b1;
    cyc();
    sl = 1'b0;
    checks++;
    if (r0 !== 4'b1000 || t0 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_after got r=%b t=%b exp 1000 0", r0, t0);
    end
    checks++;
    if (l1 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_phase1 got %b exp 0", l1);
    end
    cyc();
    checks++;
    if (t0 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_next_tick got %b exp 1", t0);
    end
    cyc();
    checks++;
    if (l1 !== 1'b1 || t0 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_phase2 got l=%b t=%b exp 1 0", l1, t0);
    end
  endtask

  task automatic test_strobe_pattern_reset();
    logic el, et;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      el = (k < 4) || (k >= 8 && k < 12);
      checks++;
      if (l1 !== el) begin
        errors++;
        $display("FAIL p1_light k=%0d got %b exp %b", k, l1, el);
      end
      cyc();
    end
    for (int k = 0; k < 22; k++) cyc();
    checks++;
    if (l1 !== 1'b0) begin
      errors++;
      $display("FAIL p1_mid got %b exp 0", l1);
    end
    reset = 1'b1;
    sl = 1'b1;
    cyc();
    reset = 1'b0;
    sl = 1'b0;
    checks++;
    if (r0 !== 4'b0100 || l1 !== 1'b1 || l0 !== 1'b1 || t0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got r=%b l1=%b l0=%b t=%b exp 0100 1 1 0",
               r0, l1, l0, t0);
    end
    for (int q = 0; q < 4; q++) begin
      et = (q == 3);
      checks++;
      if (t0 !== et) begin
        errors++;
        $display("FAIL mid_reset_tick q=%0d got %b exp %b", q, t0, et);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_idle_square();
    test_shift_left_sat();
    test_shift_right_sat();
    test_both_strobes();
    test_shift_on_wrap();
    test_strobe_pattern_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
